mcpu_soc_mmio_arb: RTL and testbench

Two-master arbiter and transaction sequencer for the SoC MMIO peripheral bus. The bus carries an address, a per-byte write enable, write data and read data. The two masters are the core's load/store path (m0) and a debug/DMA path (m1). The arbiter serialises their accesses and converts each access into a single-cycle write-enable strobe, so peripherals see exactly one write per request. For reads it waits a fixed number of cycles before capturing read data and acknowledging the requester. It sits between the masters and the MMIO address decoder.

---
 rtl/mcpu_soc_mmio_arb.sv | 189 ++++++++++++++++++
 tb/tb_mcpu_soc_mmio_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_soc_mmio_arb.sv
// ---------------------------------------------------------------------------
// mcpu_soc_mmio_arb
//
// Two-master arbiter and transaction sequencer for the SoC MMIO peripheral
// bus. It serialises accesses from the core load/store path (m0) and the
// debug/DMA path (m1). Each access becomes a single-cycle byte write-enable
// strobe on mmio_wren. Reads wait READ_LAT cycles after issue, capture
// mmio_rdata, and then acknowledge the requester.
//
// Parameters
//   READ_LAT : cycles from the issue cycle until mmio_rdata is valid (1..7)
//   FAIR     : 1 = round-robin between m0/m1, 0 = fixed priority (m0 wins)
//
// Optional feature (compile-time macro MMIO_ARB_LOCK_EN)
//   Adds m0_lock/m1_lock. A grant that carries lock=1 makes that master the
//   lock owner. While a lock is held, the other master is ignored in IDLE.
//   The owner's next grant with lock=0 releases the lock, and that
//   transaction still completes normally.
//
// Ports
//   clkrst_core_clk / clkrst_core_rst_n : clock, async active-low reset
//   mX_req/addr/wren/wdata              : master X request (held until ack)
//   mX_ack/rdata                        : one-cycle completion + read data
//   mmio_addr/wren/wdata                : request to the MMIO decoder
//   mmio_rdata                          : read data from the MMIO decoder
//   busy                                : sequencer is not IDLE
// ---------------------------------------------------------------------------
module mcpu_soc_mmio_arb #(
    parameter int unsigned READ_LAT = 1,
    parameter bit          FAIR     = 1'b1
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst_n,
    input  logic        m0_req,
    input  logic [30:2] m0_addr,
    input  logic [3:0]  m0_wren,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [30:2] m1_addr,
    input  logic [3:0]  m1_wren,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
`ifdef MMIO_ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    output logic [30:2] mmio_addr,
    output logic [3:0]  mmio_wren,
    output logic [31:0] mmio_wdata,
    input  logic [31:0] mmio_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_last_grant;   // 0 = m0, 1 = m1
    logic        r_grant;        // master owning the current transaction
    logic [2:0]  r_cnt;
    logic [30:2] r_addr;
    logic [3:0]  r_wren;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_req0;
    logic        w_req1;
    logic        w_any;
    logic        w_gnt;

`ifdef MMIO_ARB_LOCK_EN
    logic        r_lock_vld;
    logic        r_lock_owner;
    logic        w_glock;
`endif

    // Request qualification and arbitration, used only in IDLE.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_req0 = m0_req;
        w_req1 = m1_req;
`ifdef MMIO_ARB_LOCK_EN
        // A held lock hides the non-owner's request.
        w_req0 = m0_req && !(r_lock_vld && r_lock_owner);
        w_req1 = m1_req && !(r_lock_vld && !r_lock_owner);
        w_glock = 1'b0;
`endif
        w_any = w_req0 || w_req1;
        if (w_req0 && w_req1) begin
            w_gnt = FAIR ? ~r_last_grant : 1'b0;
        end else begin
            w_gnt = w_req1;
        end
`ifdef MMIO_ARB_LOCK_EN
        w_glock = w_gnt ? m1_lock : m0_lock;
`endif
    end

    // State register.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = (r_wren != 4'd0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 3'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Grant, captured request, latency counter and read data.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            // NOTE: the datapath registers are reset too, because mmio_addr/wdata and rdata are visible and must read 0 after reset.
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_cnt        <= 3'd0;
            r_addr       <= '0;
            r_wren       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
`ifdef MMIO_ARB_LOCK_EN
            r_lock_vld   <= 1'b0;
            r_lock_owner <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_addr       <= w_gnt ? m1_addr  : m0_addr;
                        r_wren       <= w_gnt ? m1_wren  : m0_wren;
                        r_wdata      <= w_gnt ? m1_wdata : m0_wdata;
`ifdef MMIO_ARB_LOCK_EN
                        if (w_glock) begin
                            r_lock_vld   <= 1'b1;
                            r_lock_owner <= w_gnt;
                        end else if (r_lock_vld && (r_lock_owner == w_gnt)) begin
                            r_lock_vld   <= 1'b0;
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    if (r_wren == 4'd0) r_cnt <= LAT_M1;
                end
                S_WAIT: begin
                    // Capture happens in the same cycle that the counter reads zero.
                    if (r_cnt == 3'd0) r_rdata <= mmio_rdata;
                    else               r_cnt   <= r_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs. Address and data hold their last values; only the strobe is
    // confined to the ISSUE cycle.
    logic w_resp;
    logic w_is_rd;

    assign w_resp     = (r_state == S_RESP);
    assign w_is_rd    = (r_wren == 4'd0);
    assign mmio_addr  = r_addr;
    assign mmio_wdata = r_wdata;
    assign mmio_wren  = (r_state == S_ISSUE) ? r_wren : 4'd0;
    assign m0_ack     = w_resp && !r_grant;
    assign m1_ack     = w_resp &&  r_grant;
    assign m0_rdata   = (m0_ack && w_is_rd) ? r_rdata : 32'd0;
    assign m1_rdata   = (m1_ack && w_is_rd) ? r_rdata : 32'd0;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mcpu_soc_mmio_arb.sv
// ---------------------------------------------------------------------------
// tb_mcpu_soc_mmio_arb
//
// Directed bench with two instances:
//   dut_a : READ_LAT=3, FAIR=1 (write, read latency, round-robin, reset,
//           and lock when MMIO_ARB_LOCK_EN is defined)
//   dut_b : READ_LAT=1, FAIR=0 (fixed priority)
// Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled at that same point.
// ---------------------------------------------------------------------------
module tb_mcpu_soc_mmio_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // dut_a signals
    logic        m0_req, m1_req, m0_ack, m1_ack, busy;
    logic [30:2] m0_addr, m1_addr, mmio_addr;
    logic [3:0]  m0_wren, m1_wren, mmio_wren;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mmio_wdata, mmio_rdata;
`ifdef MMIO_ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif
    logic        use_fn;
    logic [31:0] rdata_drv;

    // dut_b signals
    logic        b_m0_req, b_m1_req, b_m0_ack, b_m1_ack, b_busy;
    logic [30:2] b_m0_addr, b_m1_addr, b_mmio_addr;
    logic [3:0]  b_mmio_wren;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mmio_wdata, b_mmio_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    bit both_a   = 1'b0;
    bit both_b   = 1'b0;

    // Peripheral read model: data is a fixed function of the address.
    function automatic logic [31:0] rd_model(input logic [30:2] a);
        return {3'b000, a} ^ 32'h5A5A_0000;
    endfunction

    always_comb mmio_rdata = use_fn ? rd_model(mmio_addr) : rdata_drv;
    assign b_mmio_rdata = rd_model(b_mmio_addr);

    mcpu_soc_mmio_arb #(.READ_LAT(3), .FAIR(1'b1)) dut_a (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wren(m0_wren), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wren(m1_wren), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
`ifdef MMIO_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .mmio_addr(mmio_addr), .mmio_wren(mmio_wren), .mmio_wdata(mmio_wdata),
        .mmio_rdata(mmio_rdata), .busy(busy)
    );

    mcpu_soc_mmio_arb #(.READ_LAT(1), .FAIR(1'b0)) dut_b (
        .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
        .m0_req(b_m0_req), .m0_addr(b_m0_addr), .m0_wren(4'd0), .m0_wdata(32'd0),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_addr(b_m1_addr), .m1_wren(4'd0), .m1_wdata(32'd0),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
`ifdef MMIO_ARB_LOCK_EN
        .m0_lock(1'b0), .m1_lock(1'b0),
`endif
        .mmio_addr(b_mmio_addr), .mmio_wren(b_mmio_wren), .mmio_wdata(b_mmio_wdata),
        .mmio_rdata(b_mmio_rdata), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Step until dut_a acks someone. who = 0/1, or -1 if the budget runs out.
    task automatic wait_ack_a(output int who, input int budget);
        who = -1;
        for (int c = 0; c < budget; c++) begin
            cyc();
            if (m0_ack && m1_ack) both_a = 1'b1;
            if (m0_ack) begin who = 0; break; end
            if (m1_ack) begin who = 1; break; end
        end
    endtask

    task automatic wait_ack_b(output int who, input int budget);
        who = -1;
        for (int c = 0; c < budget; c++) begin
            cyc();
            if (b_m0_ack && b_m1_ack) both_b = 1'b1;
            if (b_m0_ack) begin who = 0; break; end
            if (b_m1_ack) begin who = 1; break; end
        end
    endtask

    initial begin
        int who;
        bit flag;

        rst_n = 1'b0;
        m0_req = 0; m0_addr = '0; m0_wren = '0; m0_wdata = '0;
        m1_req = 0; m1_addr = '0; m1_wren = '0; m1_wdata = '0;
`ifdef MMIO_ARB_LOCK_EN
        m0_lock = 0; m1_lock = 0;
`endif
        b_m0_req = 0; b_m1_req = 0; b_m0_addr = '0; b_m1_addr = '0;
        use_fn = 1'b1; rdata_drv = '0;

        // ---- reset state ----
        repeat (2) cyc();
        check("rst_busy",      busy,       0);
        check("rst_m0_ack",    m0_ack,     0);
        check("rst_m1_ack",    m1_ack,     0);
        check("rst_mmio_addr", mmio_addr,  0);
        check("rst_mmio_wren", mmio_wren,  0);
        check("rst_mmio_wdata",mmio_wdata, 0);
        check("rst_m0_rdata",  m0_rdata,   0);
        check("rst_b_busy",    b_busy,     0);
        check("rst_b_wren",    b_mmio_wren,0);
        rst_n = 1'b1;

        // ---- m0 write: strobe at t+1 only, ack at t+2 ----
        m0_addr = 29'h400; m0_wren = 4'hF; m0_wdata = 32'hA5; m0_req = 1;
        cyc();
        check("wr_issue_wren",  mmio_wren,  4'hF);
        check("wr_issue_addr",  mmio_addr,  29'h400);
        check("wr_issue_wdata", mmio_wdata, 32'hA5);
        check("wr_issue_noack", m0_ack,     0);
        check("wr_issue_busy",  busy,       1);
        cyc();
        check("wr_ack",         m0_ack,     1);
        check("wr_rdata",       m0_rdata,   0);
        check("wr_resp_wren",   mmio_wren,  0);
        check("wr_m1_noack",    m1_ack,     0);
        cyc();
        m0_req = 0;
        check("wr_ack_pulse",   m0_ack,     0);
        check("wr_idle_busy",   busy,       0);
        check("wr_addr_held",   mmio_addr,  29'h400);
        check("wr_wdata_held",  mmio_wdata, 32'hA5);

        // ---- m1 read, READ_LAT=3: data valid at issue+3, ack at t+5 ----
        use_fn = 1'b0; rdata_drv = 32'hBAD0_BAD0;
        m1_addr = 29'h55; m1_wren = 4'h0; m1_req = 1;
        flag = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (mmio_wren != 4'd0) flag = 1'b1;
            if (k < 5) check($sformatf("rd_noack_t%0d", k), m1_ack, 0);
            if (k == 4) rdata_drv = 32'h1234_5678;
        end
        check("rd_ack",        m1_ack,   1);
        check("rd_rdata",      m1_rdata, 32'h1234_5678);
        check("rd_m0_noack",   m0_ack,   0);
        check("rd_wren_quiet", flag,     0);
        rdata_drv = 32'hBAD0_BAD0;
        cyc();
        m1_req = 0;
        use_fn = 1'b1;

        // ---- round-robin: both request reads continuously ----
        m0_addr = 29'h100; m0_wren = 0; m1_addr = 29'h200; m1_wren = 0;
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 4; i++) begin
            wait_ack_a(who, 40);
            check($sformatf("rr_grant%0d", i), who, i % 2);
            if (who == 0) check($sformatf("rr_m0_rdata%0d", i), m0_rdata, rd_model(29'h100));
            if (who == 1) check($sformatf("rr_m1_rdata%0d", i), m1_rdata, rd_model(29'h200));
        end
        check("rr_no_dual_ack", both_a, 0);
        cyc();
        m0_req = 0; m1_req = 0;
        cyc();

        // ---- reset during WAIT: abandon, then m0 wins first contention ----
        m0_addr = 29'h333; m0_wren = 0; m0_req = 1;
        repeat (3) cyc();
        check("rst_mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy",  busy,      0);
        check("rst_mid_ack",   m0_ack,    0);
        check("rst_mid_wren",  mmio_wren, 0);
        check("rst_mid_addr",  mmio_addr, 0);
        m0_req = 0;
        flag = 1'b0;
        repeat (3) begin
            cyc();
            if (m0_ack || m1_ack || mmio_wren != 4'd0) flag = 1'b1;
        end
        check("rst_mid_quiet", flag, 0);
        rst_n = 1'b1;
        m0_addr = 29'h10; m1_addr = 29'h20; m0_req = 1; m1_req = 1;
        wait_ack_a(who, 40);
        check("post_rst_first_grant", who, 0);
        cyc();
        m0_req = 0; m1_req = 0;
        cyc();

        // ---- fixed priority (dut_b, FAIR=0) ----
        b_m0_addr = 29'h1A; b_m1_addr = 29'h2B; b_m0_req = 1; b_m1_req = 1;
        for (int i = 0; i < 3; i++) begin
            wait_ack_b(who, 20);
            check($sformatf("fp_grant%0d", i), who, 0);
            if (who == 0) check($sformatf("fp_m0_rdata%0d", i), b_m0_rdata, rd_model(29'h1A));
        end
        cyc();
        b_m0_req = 0;
        wait_ack_b(who, 20);
        check("fp_m1_served", who, 1);
        check("fp_m1_rdata", b_m1_rdata, rd_model(29'h2B));
        check("fp_no_dual_ack", both_b, 0);
        cyc();
        b_m1_req = 0;
        cyc();

`ifdef MMIO_ARB_LOCK_EN
        // ---- lock: m1 locked read, m0 pending, m1 unlocking write first ----
        m1_addr = 29'h77; m1_wren = 0; m1_lock = 1; m1_req = 1;
        cyc();
        m0_addr = 29'h66; m0_wren = 0; m0_req = 1;
        wait_ack_a(who, 40);
        check("lk_first", who, 1);
        cyc();
        m1_wren = 4'h3; m1_wdata = 32'hC0DE; m1_lock = 0;
        wait_ack_a(who, 40);
        check("lk_owner_again", who, 1);
        cyc();
        m1_req = 0;
        wait_ack_a(who, 40);
        check("lk_m0_after", who, 0);
        cyc();
        m0_req = 0;
        cyc();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
